// File: rtl/sub3_pkg.sv
// Shared types and constants for the bit-serial three-operand subtractor.
package sub3_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Borrow-save state per step: borrow values 0..2.
  localparam int unsigned BW = 2;

  function automatic int unsigned res_width(input int unsigned n);
    return n + 2;
  endfunction

endpackage

// File: rtl/sub3_cell.sv
// One borrow-save step: a - b - c - bin = d - 2*bout, with bout in 0..2.
module sub3_cell
  import sub3_pkg::*;
(
  input  logic          a,
  input  logic          b,
  input  logic          c,
  input  logic [BW-1:0] bin,
  output logic          d,
  output logic [BW-1:0] bout
);

  // s = t + 4 keeps the arithmetic unsigned (0..5); bout = 2 - floor(s/2).
  logic [2:0] s;

  always_comb begin
    s    = 3'd4 + {2'b00, a} - {2'b00, b} - {2'b00, c} - {1'b0, bin};
    d    = s[0];
    bout = 2'd2 - s[2:1];
  end

endmodule

// File: rtl/serial_sub3.sv
// Bit-serial D = A - B - C, LSB first, one bit per clock, valid/ready on both sides.
module serial_sub3
  import sub3_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            a,
  input  logic [N-1:0]            b,
  input  logic [N-1:0]            c,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [res_width(N)-1:0] diff
);

  localparam int unsigned RW = res_width(N);
  localparam int unsigned CW = $clog2(N + 2);
  localparam logic [CW-1:0] OpCnt   = CW'(N);
  localparam logic [CW-1:0] LastCnt = CW'(N + 1);

  state_e          state_q;
  logic [N-1:0]    a_q, b_q, c_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   bin_q;
  logic [RW-1:0]   res_q;
  logic            in_ready_q, out_valid_q;

  logic            a_bit, b_bit, c_bit;
  logic            d_bit;
  logic [BW-1:0]   bout;

  // Past the operand width the inputs are zero; those steps produce the sign bits.
  always_comb begin
    a_bit = 1'b0;
    b_bit = 1'b0;
    c_bit = 1'b0;
    if (cnt_q < OpCnt) begin
      a_bit = a_q[0];
      b_bit = b_q[0];
      c_bit = c_q[0];
    end
  end

  sub3_cell u_cell (
    .a    (a_bit),
    .b    (b_bit),
    .c    (c_bit),
    .bin  (bin_q),
    .d    (d_bit),
    .bout (bout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      bin_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            c_q        <= c;
            cnt_q      <= '0;
            bin_q      <= '0;
            res_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          res_q <= {d_bit, res_q[RW-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_q >> 1;
          bin_q <= bout;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LastCnt) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = res_q;

endmodule
